// File: rtl/bit_stream_pkg.sv
// rtl/bit_stream_pkg.sv - shared defaults, state encoding and sizing helper for the bit stream link
package bit_stream_pkg;

  localparam int CLK_LEN_DEF      = 24;
  localparam int DATA_W_DEF       = 8;
  localparam int PREAMBLE_LEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } tx_state_e;

  // Bit-index counter must hold both the preamble and the word bit index.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bit_stream_tx_bit_timer.sv
// rtl/bit_stream_tx_bit_timer.sv - bit period counter flagging the last cycle of each bit
module bit_timer
  import bit_stream_pkg::*;
#(
  parameter int CLK_LEN = CLK_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CLK_LEN-1:0] period,
  input  logic               restart,
  output logic               boundary
);

  localparam logic [CLK_LEN-1:0] ONE = CLK_LEN'(1);

  logic [CLK_LEN-1:0] cnt_q;
  logic [CLK_LEN-1:0] cnt_d;

  assign boundary = (cnt_q == (period - ONE));

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (restart || boundary) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_stream_tx.sv
// rtl/bit_stream_tx.sv - NRZ serialiser: alternating preamble then back-to-back payload words
module bit_stream_tx
  import bit_stream_pkg::*;
#(
  parameter int CLK_LEN      = CLK_LEN_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CLK_LEN-1:0] bit_period,
  input  logic               msb_first,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               signal,
  output logic               bit_strobe,
  output logic               tx_busy
);

  localparam int CNT_W = cnt_width(PREAMBLE_LEN, DATA_W);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   PRE_LAST   = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CLK_LEN-1:0] MIN_PERIOD = CLK_LEN'(2);

  tx_state_e          state_q, state_d;
  logic               signal_q, signal_d;
  logic               strobe_q, strobe_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CLK_LEN-1:0] period_q, period_d;
  logic               msb_q, msb_d;

  logic               accept;
  logic               do_load;
  logic [DATA_W-1:0]  load_word;
  logic               boundary;

  assign accept     = data_valid && !hold_full_q;
  assign data_ready = !hold_full_q;
  assign signal     = signal_q;
  assign bit_strobe = strobe_q;
  assign tx_busy    = (state_q != ST_IDLE);

  bit_timer #(
    .CLK_LEN (CLK_LEN)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .period   (period_q),
    .restart  (state_q == ST_IDLE),
    .boundary (boundary)
  );

  always_comb begin
    state_d     = state_q;
    signal_d    = signal_q;
    strobe_d    = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    period_d    = period_q;
    msb_d       = msb_q;
    do_load     = 1'b0;
    load_word   = hold_full_q ? hold_q : data_in;

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        signal_d = 1'b1;
        if (hold_full_q) begin
          state_d   = ST_PREAMBLE;
          signal_d  = 1'b0;
          strobe_d  = 1'b1;
          bit_cnt_d = '0;
          period_d  = (bit_period < MIN_PERIOD) ? MIN_PERIOD : bit_period;
          msb_d     = msb_first;
        end
      end
      ST_PREAMBLE: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            do_load   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            signal_d  = ~signal_q;
          end
        end
      end
      ST_DATA: begin
        if (boundary) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            // A word arriving on this very cycle is taken straight from data_in.
            if (hold_full_q || data_valid) begin
              do_load  = 1'b1;
              strobe_d = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              signal_d = 1'b1;
            end
          end else begin
            strobe_d  = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            signal_d  = msb_q ? shift_q[DATA_W-1] : shift_q[0];
            shift_d   = msb_q ? (shift_q << 1) : (shift_q >> 1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        signal_d = 1'b1;
      end
    endcase

    if (do_load) begin
      signal_d    = msb_q ? load_word[DATA_W-1] : load_word[0];
      shift_d     = msb_q ? (load_word << 1) : (load_word >> 1);
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      signal_q    <= 1'b1;
      strobe_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      period_q    <= MIN_PERIOD;
      msb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      signal_q    <= signal_d;
      strobe_q    <= strobe_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      period_q    <= period_d;
      msb_q       <= msb_d;
    end
  end

endmodule

// File: tb/tb_bit_stream_tx.sv
// tb/tb_bit_stream_tx.sv - directed self-checking bench for bit_stream_tx
module tb_bit_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] bit_period;
  logic        msb_first;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        signal;
  logic        bit_strobe;
  logic        tx_busy;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  bit_stream_tx dut (
    .clk        (clk),
    .rst        (rst),
    .bit_period (bit_period),
    .msb_first  (msb_first),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .signal     (signal),
    .bit_strobe (bit_strobe),
    .tx_busy    (tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents nw words from cycle 0 and compares every cycle of the burst
  // against a waveform built from the bit period the burst should use.
  task automatic burst(input string tag, input int p_drive, input int p_exp, input int p_mid,
                       input logic msb, input int nw, input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input bit late);
    logic [7:0] wq [3];
    int total, ncyc, idx, errs, first_c, nstb, t, b, j, k;
    logic exp_sig, exp_stb, exp_busy, drv, pend;
    wq[0] = w0; wq[1] = w1; wq[2] = w2;
    total = 32 + 8 * nw;
    ncyc  = 2 + total * p_exp + 4;
    idx = 0; errs = 0; first_c = -1; nstb = 0; pend = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_sig = 1'b1; exp_stb = 1'b0; exp_busy = 1'b0;
      if (c >= 2) begin
        t = c - 2;
        b = t / p_exp;
        if (b < total) begin
          exp_busy = 1'b1;
          exp_stb  = ((t % p_exp) == 0);
          if (b < 32) begin
            exp_sig = b[0];
          end else begin
            j = (b - 32) % 8;
            k = (b - 32) / 8;
            exp_sig = msb ? wq[k][7-j] : wq[k][j];
          end
        end
      end
      if (signal !== exp_sig || bit_strobe !== exp_stb || tx_busy !== exp_busy) begin
        if (errs == 0) first_c = c;
        errs++;
      end
      if (bit_strobe === 1'b1) nstb++;
      if (c == 1) check({tag, " ready_while_hold_full"}, {31'd0, data_ready}, 32'd0);
      if (pend) begin
        idx++;
        pend = 1'b0;
      end
      if (c == 0) begin
        bit_period = p_drive[23:0];
        msb_first  = msb;
      end
      if (c == 10 && p_mid >= 0) begin
        bit_period = p_mid[23:0];
        msb_first  = ~msb;
      end
      drv = (idx < nw) && (!late || idx == 0 || c >= 2 + (32 + 8 * idx) * p_exp - 1);
      data_valid = drv;
      data_in    = drv ? wq[idx] : 8'h00;
      pend       = drv && (data_ready === 1'b1);
    end
    check($sformatf("%s waveform_errors(first_cycle=%0d)", tag, first_c), errs, 0);
    check({tag, " strobe_count"}, nstb, total);
    check({tag, " words_accepted"}, idx, nw);
    check({tag, " idle_after"}, {30'd0, signal, data_ready}, 32'd3);
  endtask

  initial begin
    int bad;
    rst = 1'b1; bit_period = 24'd4; msb_first = 1'b1; data_in = 8'h00; data_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset signal",     {31'd0, signal},     32'd1);
    check("reset bit_strobe", {31'd0, bit_strobe}, 32'd0);
    check("reset tx_busy",    {31'd0, tx_busy},    32'd0);
    check("reset data_ready", {31'd0, data_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    burst("p4_a5",      4, 4, -1, 1'b1, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
    burst("p0_clamp",   0, 2, -1, 1'b1, 1, 8'h3C, 8'h00, 8'h00, 1'b0);
    burst("p1_clamp",   1, 2, -1, 1'b0, 1, 8'h81, 8'h00, 8'h00, 1'b0);
    burst("b2b_lsb",    3, 3, -1, 1'b0, 3, 8'h00, 8'hFF, 8'h3C, 1'b0);
    burst("p6_change",  6, 6,  3, 1'b1, 2, 8'hC3, 8'h5A, 8'h00, 1'b0);
    burst("p3_next",    3, 3, -1, 1'b0, 1, 8'h96, 8'h00, 8'h00, 1'b0);
    burst("bypass",     2, 2, -1, 1'b1, 2, 8'h12, 8'h34, 8'h00, 1'b1);

    // Reset in the middle of the 3rd data bit: p=4, data bit 2 spans cycles 138..141.
    @(negedge clk);
    bit_period = 24'd4; msb_first = 1'b1; data_in = 8'h55; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (138) @(negedge clk);
    check("rst_mid in_burst", {31'd0, tx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid signal",     {31'd0, signal},     32'd1);
    check("rst_mid tx_busy",    {31'd0, tx_busy},    32'd0);
    check("rst_mid data_ready", {31'd0, data_ready}, 32'd1);
    check("rst_mid bit_strobe", {31'd0, bit_strobe}, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (signal !== 1'b1 || bit_strobe !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    check("rst_mid quiet_after", bad, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/bit_stream_tx.md
BIT_STREAM_TX -- requirements
Module: bit_stream_tx

Interface
REQ-001 Parameter CLK_LEN, default 24: width of bit-period and bit counters, in base-clock cycles.
REQ-002 Parameter DATA_W, default 8: payload word width.
REQ-003 Parameter PREAMBLE_LEN, default 32: number of alternating preamble bits sent before the first word of a burst.
REQ-004 clk  input  1  base clock; one clock; reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bit_period  input  CLK_LEN  bit duration in clk cycles; sampled only on burst start.
REQ-007 msb_first  input  1  word bit order (1 = MSB first); sampled only on burst start.
REQ-008 data_in  input  DATA_W  payload word.
REQ-009 data_valid  input  1  data_in valid.
REQ-010 data_ready  output  1  block can accept a word this cycle.
REQ-011 signal  output  1  serial NRZ line; the matching clock-recovery receiver consumes it.
REQ-012 bit_strobe  output  1  one-cycle pulse on the first cycle of every transmitted bit, preamble included.
REQ-013 tx_busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL have states IDLE, PREAMBLE and DATA.
REQ-015 A word is accepted on any cycle with data_valid and data_ready both high.
REQ-016 Accepted words go into a one-entry hold register; data_ready SHALL equal "hold register empty".
REQ-017 IDLE: signal held at 1.
REQ-018 IDLE -> PREAMBLE on the cycle after the hold register becomes full.
  - Latch bit_period into period_q; values below 2 clamp to 2.
  - Latch msb_first.
REQ-019 A bit counter SHALL count 0..period_q-1; the bit boundary is the cycle where it equals period_q-1.
  - At the boundary, the next bit drives signal on the following cycle, with bit_strobe high on that cycle.
REQ-020 PREAMBLE: PREAMBLE_LEN bits alternating 0,1,0,1..., first bit 0, so every second bit boundary is a falling edge.
REQ-021 PREAMBLE -> DATA at the last preamble boundary.
  - Hold register content moves to the shift register; the hold register empties.
REQ-022 DATA: send DATA_W bits of the shift register in the latched order.
REQ-023 At the last-bit boundary of a word:
  - If the hold register is full: move it to the shift register and continue DATA with no gap cycles.
  - Otherwise: go to IDLE and drive signal=1 from the next cycle.
REQ-024 A word accepted in the same cycle as a last-bit boundary SHALL be used immediately.
  - The boundary move takes data_in directly (bypass), and the hold register stays empty.
REQ-025 bit_period and msb_first changes while tx_busy is high SHALL have no effect until the next burst.
REQ-026 First-bit latency: signal drives the first preamble bit 2 cycles after the accepting cycle (accept cycle, hold-full cycle, then first preamble cycle).
REQ-027 The bit counter SHALL never wrap inside a bit, since period_q ≤ 2^CLK_LEN-1.
  - period_q = 2^CLK_LEN-1 is legal.

Reset
REQ-028 While rst is high, on the next clk edge:
  - state=IDLE, signal=1, bit_strobe=0, tx_busy=0, data_ready=1;
  - hold register empty, counters 0, shift register 0.
REQ-029 Reset mid-burst SHALL abort the burst immediately and discard the hold register; no partial bits follow reset release.

Structure
REQ-030 State encoding and the default CLK_LEN, DATA_W and PREAMBLE_LEN values SHALL live in a shared package bit_stream_pkg.
  - The receiver side uses the same CLK_LEN.
REQ-031 The period counter with boundary output SHALL be a sub-module bit_timer (inputs clk, rst, period, restart; output boundary).

Verification
REQ-032 bit_period=4, msb_first=1, one word 0xA5 → signal = 32 preamble bits 0101…, then 1,0,1,0,0,1,0,1, each bit exactly 4 cycles long, then 1 idle; bit_strobe count = 40.
REQ-033 bit_period=0 → bit length 2 cycles (clamp); bit_period=1 → bit length 2 cycles.
REQ-034 Back-to-back 0x00, 0xFF, 0x3C with data_valid held high, msb_first=0 → no gap between words; data_ready low while the hold register is full; exactly 24 data bits sent.
REQ-035 Change bit_period from 6 to 3 mid-burst → all bits of the burst stay 6 cycles; the next burst uses 3.
REQ-036 Assert rst for 1 cycle in the middle of the 3rd data bit → next cycle signal=1, tx_busy=0, data_ready=1; no further transitions until a new word is accepted.
REQ-037 Loopback: signal into the clock-recovery receiver with bit_period=30 → receiver clk_freq settles to 30 (±1) within the preamble.
